// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-requester data-memory arbiter.
// Defines the FSM state type, the requester id type and the id constants.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef logic req_id_t;

    localparam req_id_t REQ_CPU = 1'b0;
    localparam req_id_t REQ_DMA = 1'b1;

    // One-hot request-vector bit for a requester id
    function automatic logic [1:0] id_onehot(input req_id_t id);
        return (id == REQ_DMA) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/arb_rr_select.sv
// Two-way round-robin selector (purely combinational).
// A masked requester is never eligible; with both eligible the one that
// did not win last time is chosen.
module arb_rr_select
    import dmem_arb_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic [1:0] i_mask,
    input  req_id_t    i_last_grant,
    output logic       o_valid,
    output req_id_t    o_grant
);

    logic [1:0] w_elig;

    assign w_elig = i_req & ~i_mask;

    // Pick the single eligible requester, or alternate when both compete
    always_comb begin
        o_valid = |w_elig;
        o_grant = REQ_CPU;
        if (w_elig == 2'b11) begin
            o_grant = ~i_last_grant;
        end else if (w_elig == 2'b10) begin
            o_grant = REQ_DMA;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter sharing the single-port dmem between the CPU data port (0) and the
// DMA/debug loader port (1). One access per grant: IDLE -> ACCESS -> RESP,
// with back-to-back grants issued from RESP.
// Optional feature: define ARB_LOCK_EN to let a winner keep ownership via its
// lock input for up to MAX_LOCK consecutive grants.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_LOCK = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    input  logic          lock0,
    input  logic          lock1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          mem_we,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd,
    output logic          busy
);

    state_t        r_state;
    req_id_t       r_winner;
    req_id_t       r_last_grant;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [1:0]    r_ack;
    logic [DW-1:0] r_rdata [2];

    logic [1:0]    w_req;
    logic [1:0]    w_mask;
    logic          w_keep;
    logic          w_sel_valid;
    req_id_t       w_sel_grant;
    logic          w_finish;

    assign w_req    = {req1, req0};
    assign w_finish = (r_state == ACCESS);

`ifdef ARB_LOCK_EN
    localparam int CW = $clog2(MAX_LOCK + 1);

    logic [1:0]    w_lock;
    logic [CW-1:0] r_lock_cnt;
    logic          r_owned;
    logic [CW-1:0] w_cnt_inc;

    assign w_lock    = {lock1, lock0};
    assign w_cnt_inc = r_lock_cnt + CW'(1);
    // Owner is re-granted only while it still requests
    assign w_keep    = r_owned && w_req[r_winner];

    // Track ownership: set by lock in ACCESS, dropped by unlock, idle owner or the grant cap
    always_ff @(posedge clk) begin
        if (reset) begin
            r_owned    <= 1'b0;
            r_lock_cnt <= '0;
        end else if (r_state == ACCESS) begin
            if (w_lock[r_winner] && (w_cnt_inc < CW'(MAX_LOCK))) begin
                r_owned    <= 1'b1;
                r_lock_cnt <= w_cnt_inc;
            end else begin
                r_owned    <= 1'b0;
                r_lock_cnt <= '0;
            end
        end else if ((r_state == RESP) && r_owned && !w_req[r_winner]) begin
            r_owned    <= 1'b0;
            r_lock_cnt <= '0;
        end
    end
`else
    logic w_unused_lock;

    assign w_keep        = 1'b0;
    assign w_unused_lock = lock0 ^ lock1 ^ (MAX_LOCK > 0);
`endif

    // In RESP mask the just-served requester, or the other one while ownership is kept
    always_comb begin
        w_mask = 2'b00;
        if (r_state == RESP) begin
            w_mask = w_keep ? id_onehot(~r_winner) : id_onehot(r_winner);
        end
    end

    arb_rr_select u_sel (
        .i_req        (w_req),
        .i_mask       (w_mask),
        .i_last_grant (r_last_grant),
        .o_valid      (w_sel_valid),
        .o_grant      (w_sel_grant)
    );

    // Main FSM: latch the winner's transaction, run one access, then respond
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_winner     <= REQ_CPU;
            r_last_grant <= REQ_DMA;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
        end else begin
            case (r_state)
                IDLE, RESP: begin
                    if (w_sel_valid) begin
                        r_winner <= w_sel_grant;
                        r_we     <= (w_sel_grant == REQ_DMA) ? we1 : we0;
                        r_addr   <= (w_sel_grant == REQ_DMA) ? addr1 : addr0;
                        r_wdata  <= (w_sel_grant == REQ_DMA) ? wdata1 : wdata0;
                        r_state  <= ACCESS;
                    end else begin
                        r_state  <= IDLE;
                    end
                end
                ACCESS: begin
                    r_last_grant <= r_winner;
                    r_state      <= RESP;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Per-requester response: ack pulse and read-data capture at the end of ACCESS
    for (genvar gi = 0; gi < 2; gi++) begin : g_resp
        localparam req_id_t ID = req_id_t'(gi);

        always_ff @(posedge clk) begin
            if (reset) begin
                r_ack[gi]   <= 1'b0;
                r_rdata[gi] <= '0;
            end else begin
                r_ack[gi] <= w_finish && (r_winner == ID);
                if (w_finish && (r_winner == ID) && !r_we) begin
                    r_rdata[gi] <= mem_rd;
                end
            end
        end
    end

    // Reset also gates the write strobe so a write in flight is not committed
    // on the reset edge.
    assign mem_we = (r_state == ACCESS) && r_we && !reset;
    assign mem_a  = r_addr;
    assign mem_wd = r_wdata;
    assign busy   = (r_state != IDLE);
    assign ack0   = r_ack[0];
    assign ack1   = r_ack[1];
    assign rdata0 = r_rdata[0];
    assign rdata1 = r_rdata[1];

endmodule

// File: tb/tb_dmem_arbiter.sv
`timescale 1ns/1ps
module tb_dmem_arbiter;

    localparam int AW       = 32;
    localparam int DW       = 32;
    localparam int MAX_LOCK = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0, req1, we0, we1, lock0, lock1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          ack0, ack1;
    logic [DW-1:0] rdata0, rdata1;
    logic          mem_we;
    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_wd;
    logic [DW-1:0] mem_rd;
    logic          busy;

    logic          mem_init;
    logic [31:0]   dmem    [16];
    logic [31:0]   ref_mem [16];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(AW), .DW(DW), .MAX_LOCK(MAX_LOCK)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .lock0(lock0), .lock1(lock1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd),
        .busy(busy)
    );

    function automatic logic [31:0] init_word(input int i);
        return (i == 4) ? 32'hDEAD_BEEF : (32'hA5A5_0000 | 32'(i));
    endfunction

    // Bench-side single-port memory: combinational read, write on clock edge
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++) dmem[i] <= init_word(i);
        end else if (mem_we) begin
            dmem[mem_a[5:2]] <= mem_wd;
        end
    end
    assign mem_rd = dmem[mem_a[5:2]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic who, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
        if (who) begin
            req1 = r; we1 = w; addr1 = a; wdata1 = d;
        end else begin
            req0 = r; we0 = w; addr0 = a; wdata0 = d;
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1; mem_init = 1'b1;
        req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0; mem_init = 1'b0;
        @(negedge clk);
        chk("reset ack0",   ack0,   0);
        chk("reset ack1",   ack1,   0);
        chk("reset rdata0", rdata0, 0);
        chk("reset rdata1", rdata1, 0);
        chk("reset mem_we", mem_we, 0);
        chk("reset mem_a",  mem_a,  0);
        chk("reset mem_wd", mem_wd, 0);
        chk("reset busy",   busy,   0);
    endtask

    // Expected requester of the k-th grant when both requesters hold req
    function automatic int exp_grant(input int k, input bit locked);
`ifdef ARB_LOCK_EN
        if (locked) return ((k % (MAX_LOCK + 1)) == MAX_LOCK) ? 1 : 0;
`endif
        return k % 2;
    endfunction

    // Hold both requests and record the first n grants
    task automatic both_held(input int n, input bit l0, input string tag);
        int g_who[$];
        int g_cyc[$];
        do_reset();
        @(posedge clk); #1;
        lock0 = l0;
        drive(1'b0, 1'b1, 1'b0, 32'h0000_0000, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h0000_0004, 32'h0);
        for (int c = 0; c < 60 && g_who.size() < n; c++) begin
            @(negedge clk);
            if (ack0 || ack1) begin
                chk({tag, " ack onehot"}, 32'(ack0 & ack1), 0);
                g_who.push_back(ack1 ? 1 : 0);
                g_cyc.push_back(c);
            end
        end
        chk({tag, " grant count"}, g_who.size(), n);
        for (int k = 0; k < g_who.size(); k++) begin
            chk($sformatf("%s grant%0d who", tag, k), g_who[k], exp_grant(k, l0));
            if (k == 0) chk($sformatf("%s first ack cycle", tag), g_cyc[0], 2);
            else        chk($sformatf("%s grant%0d gap", tag, k), g_cyc[k] - g_cyc[k-1], 2);
        end
        @(posedge clk); #1;
        req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk({tag, " drained"}, busy, 0);
    endtask

    typedef struct {
        logic        who;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [6];

    // Random-phase model state
    logic        pend   [2];
    logic        p_we   [2];
    logic [31:0] p_addr [2];
    logic [31:0] p_wd   [2];
    logic [31:0] last_rd[2];
    int          age    [2];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; mem_init = 1'b1;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;

        vecs[0] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,          32'hDEAD_BEEF};
        vecs[1] = '{1'b1, 1'b1, 32'hC000_0004, 32'h0000_03FF, 32'h0000_0000};
        vecs[2] = '{1'b1, 1'b0, 32'hC000_0004, 32'h0,          32'h0000_03FF};
        vecs[3] = '{1'b0, 1'b1, 32'h0000_0013, 32'h1234_5678, 32'hDEAD_BEEF};
        vecs[4] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,          32'h1234_5678};
        vecs[5] = '{1'b1, 1'b0, 32'h0000_0020, 32'h0,          32'hA5A5_0008};

        // Single transactions from IDLE, table driven
        do_reset();
        for (int v = 0; v < 6; v++) begin
            @(posedge clk); #1;
            drive(vecs[v].who, 1'b1, vecs[v].we, vecs[v].addr, vecs[v].wdata);
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("v%0d access mem_we", v), mem_we, vecs[v].we);
            chk($sformatf("v%0d access mem_a", v),  mem_a,  vecs[v].addr);
            if (vecs[v].we) chk($sformatf("v%0d access mem_wd", v), mem_wd, vecs[v].wdata);
            chk($sformatf("v%0d access busy", v), busy, 1);
            chk($sformatf("v%0d access no ack", v), 32'(ack0 | ack1), 0);
            @(negedge clk);
            chk($sformatf("v%0d resp ack", v), vecs[v].who ? ack1 : ack0, 1);
            chk($sformatf("v%0d resp other ack", v), vecs[v].who ? ack0 : ack1, 0);
            chk($sformatf("v%0d resp rdata", v), vecs[v].who ? rdata1 : rdata0, vecs[v].exp_rdata);
            chk($sformatf("v%0d resp mem_we", v), mem_we, 0);
            @(posedge clk); #1;
            drive(vecs[v].who, 1'b0, 1'b0, vecs[v].addr, 32'h0);
            @(negedge clk);
            chk($sformatf("v%0d after ack", v), 32'(ack0 | ack1), 0);
            chk($sformatf("v%0d after busy", v), busy, 0);
        end

        // Both held: strict alternation; with lock0 the owner keeps up to MAX_LOCK grants
        both_held(8, 1'b0, "alt");
        both_held(8, 1'b1, "lock0");

        // Reset arriving during the ACCESS cycle of a write
        do_reset();
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 1'b1, 32'h0000_0008, 32'h0000_BEEF);
        @(posedge clk);
        @(negedge clk);
        chk("rst_acc mem_we before", mem_we, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("rst_acc mem_we after", mem_we, 0);
        chk("rst_acc ack1", ack1, 0);
        chk("rst_acc ack0", ack0, 0);
        chk("rst_acc busy", busy, 0);
        chk("rst_acc rdata1", rdata1, 0);
        chk("rst_acc mem not written", dmem[2], 32'hA5A5_0002);
        @(negedge clk);
        chk("rst_acc stays idle", busy, 0);

        // Requester drops req right after being latched
        do_reset();
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b0, 32'h0000_0014, 32'h0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 32'h0000_0014, 32'h0);
        begin
            int n_ack0 = 0;
            int n_ack1 = 0;
            int n_busy = 0;
            logic [31:0] rd_seen = '0;
            for (int c = 0; c < 8; c++) begin
                @(negedge clk);
                if (ack0) begin n_ack0++; rd_seen = rdata0; end
                if (ack1) n_ack1++;
                if (busy) n_busy++;
            end
            chk("drop ack0 pulses", n_ack0, 1);
            chk("drop ack1 pulses", n_ack1, 0);
            chk("drop busy cycles", n_busy, 2);
            chk("drop rdata0", rd_seen, 32'hA5A5_0005);
        end

        // Randomized traffic against a transaction-level reference
        do_reset();
        for (int i = 0; i < 16; i++) ref_mem[i] = dmem[i];
        for (int i = 0; i < 2; i++) begin
            pend[i] = 1'b0; last_rd[i] = '0; age[i] = 0;
            p_we[i] = 1'b0; p_addr[i] = '0; p_wd[i] = '0;
        end
        begin
            bit exp_active = 0;
            int exp_who = 0;
            int exp_cyc = 0;
            for (int c = 0; c < 2200; c++) begin
                @(negedge clk);
                if (ack0 || ack1) chk("rnd ack onehot", 32'(ack0 & ack1), 0);
                if (exp_active && c == exp_cyc) begin
                    chk("rnd rr next grant", (exp_who == 1) ? ack1 : ack0, 1);
                    exp_active = 0;
                end
                for (int i = 0; i < 2; i++) begin
                    logic a;
                    int idx;
                    a = (i == 1) ? ack1 : ack0;
                    idx = int'(p_addr[i][5:2]);
                    if (a) begin
                        chk($sformatf("rnd ack%0d expected", i), 32'(a), 32'(pend[i]));
                        if (pend[i]) begin
                            if (p_we[i]) begin
                                ref_mem[idx] = p_wd[i];
                                chk($sformatf("rnd wr%0d rdata kept", i),
                                    (i == 1) ? rdata1 : rdata0, last_rd[i]);
                            end else begin
                                chk($sformatf("rnd rd%0d rdata", i),
                                    (i == 1) ? rdata1 : rdata0, ref_mem[idx]);
                                last_rd[i] = ref_mem[idx];
                            end
                            pend[i] = 1'b0;
                            age[i] = 0;
                            if (pend[1-i]) begin
                                exp_active = 1;
                                exp_who = 1 - i;
                                exp_cyc = c + 2;
                            end
                        end
                    end else if (pend[i]) begin
                        age[i]++;
                        if (age[i] > 8) begin
                            chk($sformatf("rnd req%0d wait bound", i), age[i], 8);
                            pend[i] = 1'b0;
                            age[i] = 0;
                        end
                    end
                end
                if (c >= 2000 && !pend[0] && !pend[1]) break;
                @(posedge clk); #1;
                for (int i = 0; i < 2; i++) begin
                    if (!pend[i]) begin
                        if (c < 2000 && $urandom_range(2) == 0) begin
                            pend[i]   = 1'b1;
                            p_we[i]   = 1'($urandom_range(1));
                            p_addr[i] = $urandom();
                            p_wd[i]   = $urandom();
                            drive(1'(i), 1'b1, p_we[i], p_addr[i], p_wd[i]);
                        end else begin
                            drive(1'(i), 1'b0, 1'b0, p_addr[i], p_wd[i]);
                        end
                    end
                end
            end
        end
        @(posedge clk); #1;
        req0 = 1'b0; req1 = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("rnd final mem[%0d]", i), dmem[i], ref_mem[i]);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
